dmem_port_arbiter: RTL and testbench

Shares the single-port, byte-addressed, big-endian 32-bit data memory between two requesters. Port A is the pipeline MEM stage and has priority. Port B is the debug/program loader. The block sequences each access over a fixed memory latency and returns read data and a done pulse. It enforces word alignment and prevents indefinite starvation of port B.

---
 rtl/dmem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data memory port between the MEM stage (A)
// and the debug loader (B), with fixed latency, alignment check and anti-starvation.
module dmem_port_arbiter #(
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_done,
  output logic        a_err,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_done,
  output logic        b_err,
  output logic [31:0] b_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ERR
  } state_t;

  localparam logic [3:0] LAT  = 4'(MEM_LAT);
  localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic        own_b_q, own_b_d;
  logic        op_we_q, op_we_d;
  logic [3:0]  lat_q, lat_d;
  logic [3:0]  starve_q, starve_d;
  logic        a_gnt_q, a_gnt_d;
  logic        a_done_q, a_done_d;
  logic        a_err_q, a_err_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic        b_gnt_q, b_gnt_d;
  logic        b_done_q, b_done_d;
  logic        b_err_q, b_err_d;
  logic [31:0] b_rdata_q, b_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        busy_q, busy_d;

  logic        pick_b;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  // Pick the winner among live requests; B wins a conflict once starved
  always_comb begin
    pick_b    = b_req && (!a_req || starve_q == SLIM);
    sel_we    = pick_b ? b_we    : a_we;
    sel_addr  = pick_b ? b_addr  : a_addr;
    sel_wdata = pick_b ? b_wdata : a_wdata;
  end

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    own_b_d     = own_b_q;
    op_we_d     = op_we_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    a_gnt_d     = 1'b0;
    a_done_d    = 1'b0;
    a_err_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_gnt_d     = 1'b0;
    b_done_d    = 1'b0;
    b_err_d     = 1'b0;
    b_rdata_d   = b_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          own_b_d = pick_b;
          op_we_d = sel_we;
          a_gnt_d = !pick_b;
          b_gnt_d = pick_b;
          if (pick_b || !b_req) begin
            starve_d = '0;
          end else if (starve_q != SLIM) begin
            starve_d = starve_q + 4'd1;
          end
          if (sel_addr[1:0] == 2'b00) begin
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
            mem_we_d    = sel_we;
            lat_d       = LAT;
            state_d     = ACCESS;
          end else begin
            state_d = ERR;
          end
        end
      end
      ACCESS: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          state_d = IDLE;
          if (own_b_q) begin
            b_done_d = 1'b1;
            if (!op_we_q) b_rdata_d = mem_rdata;
          end else begin
            a_done_d = 1'b1;
            if (!op_we_q) a_rdata_d = mem_rdata;
          end
        end
      end
      ERR: begin
        state_d  = IDLE;
        a_done_d = !own_b_q;
        a_err_d  = !own_b_q;
        b_done_d = own_b_q;
        b_err_d  = own_b_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counters and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      own_b_q     <= 1'b0;
      op_we_q     <= 1'b0;
      lat_q       <= '0;
      starve_q    <= '0;
      a_gnt_q     <= 1'b0;
      a_done_q    <= 1'b0;
      a_err_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_gnt_q     <= 1'b0;
      b_done_q    <= 1'b0;
      b_err_q     <= 1'b0;
      b_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_b_q     <= own_b_d;
      op_we_q     <= op_we_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      a_gnt_q     <= a_gnt_d;
      a_done_q    <= a_done_d;
      a_err_q     <= a_err_d;
      a_rdata_q   <= a_rdata_d;
      b_gnt_q     <= b_gnt_d;
      b_done_q    <= b_done_d;
      b_err_q     <= b_err_d;
      b_rdata_q   <= b_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
    end
  end

  assign a_gnt     = a_gnt_q;
  assign a_done    = a_done_q;
  assign a_err     = a_err_q;
  assign a_rdata   = a_rdata_q;
  assign b_gnt     = b_gnt_q;
  assign b_done    = b_done_q;
  assign b_err     = b_err_q;
  assign b_rdata   = b_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: randomized two-port traffic against a
// transaction-level arbitration/memory model with a queue scoreboard.
module tb_dmem_port_arbiter;

  localparam int MEM_LAT      = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, busy;

  dmem_port_arbiter #(
    .MEM_LAT(MEM_LAT),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'h5A00_0000 ^ (i * 32'h0101_0307);
  endfunction

  // Memory attached to the DUT
  logic [31:0] mem [0:63];
  bit          wr_v [0:63];
  assign mem_rdata = wr_v[mem_addr[7:2]] ? mem[mem_addr[7:2]]
                                         : init_val(int'(mem_addr[7:2]));
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[7:2]]  <= mem_wdata;
      wr_v[mem_addr[7:2]] <= 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  typedef struct {
    bit          port;
    bit          err;
    bit          we;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t gq [$];
  exp_t dq [$];

  // Reference model state
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd [2];
  logic [31:0] last_maddr = '0;
  int          starve_m = 0;
  int          next_wait = 1;
  bit          a_pend = 0, b_pend = 0;
  bit          mon_en = 0;

  function automatic logic [31:0] ref_rd(input int i);
    return ref_mem.exists(i) ? ref_mem[i] : init_val(i);
  endfunction

  // Monitor: checks grants and completions against queued expectations
  exp_t mg, md;
  int   gnt_cyc = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_gnt || b_gnt) begin
        if (gq.size() == 0) begin
          fail("gnt_unexpected");
        end else begin
          mg = gq.pop_front();
          chk("gnt_port_b", {31'b0, b_gnt}, {31'b0, mg.port});
          chk("gnt_port_a", {31'b0, a_gnt}, {31'b0, !mg.port});
          chk("mem_we", {31'b0, mem_we}, {31'b0, mg.we && !mg.err});
          chk("mem_addr", mem_addr, mg.maddr);
          if (mg.we && !mg.err) chk("mem_wdata", mem_wdata, mg.wdata);
          chk("busy_at_gnt", {31'b0, busy}, 32'd1);
          gnt_cyc = cyc;
        end
      end else if (mem_we) begin
        fail("mem_we_stray");
      end
      if (a_done || b_done) begin
        if (dq.size() == 0) begin
          fail("done_unexpected");
        end else begin
          md = dq.pop_front();
          chk("done_port_b", {31'b0, b_done}, {31'b0, md.port});
          chk("done_port_a", {31'b0, a_done}, {31'b0, !md.port});
          chk("err", {31'b0, md.port ? b_err : a_err}, {31'b0, md.err});
          chk("err_other", {31'b0, md.port ? a_err : b_err}, 32'd0);
          chk("rdata", md.port ? b_rdata : a_rdata, md.rdata);
          chk("latency", cyc - gnt_cyc, md.err ? 1 : MEM_LAT);
        end
      end else if (a_err || b_err) begin
        fail("err_stray");
      end
    end
  end

  task automatic set_req(input bit p, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    if (p) begin
      b_pend = 1; b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_pend = 1; a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    end
  endtask

  task automatic set_rand(input bit p);
    logic [7:0] byt;
    byt = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 4) != 0) byt[1:0] = 2'b00;
    set_req(p, 1'($urandom_range(0, 1)), {24'h0, byt}, $urandom);
  endtask

  task automatic spawn(input bit both);
    if (!a_pend && (both || $urandom_range(0, 1) == 1)) set_rand(0);
    if (!b_pend && (both || $urandom_range(0, 2) == 0)) set_rand(1);
    if (!a_pend && !b_pend) set_rand(0);
  endtask

  // Predict one arbitration round, then wait for its grant
  task automatic issue();
    exp_t        e;
    bit          w;
    logic [31:0] ad;
    int          n;
    w  = b_pend && (!a_pend || starve_m == STARVE_LIMIT);
    if (w || !b_pend) starve_m = 0;
    else if (starve_m < STARVE_LIMIT) starve_m++;
    ad = w ? b_addr : a_addr;
    e.port  = w;
    e.we    = w ? b_we : a_we;
    e.wdata = w ? b_wdata : a_wdata;
    e.err   = (ad[1:0] != 2'b00);
    if (!e.err) last_maddr = ad;
    e.maddr = last_maddr;
    e.rdata = last_rd[w];
    if (!e.err && !e.we) e.rdata = ref_rd(int'(ad[7:2]));
    if (!e.err && e.we) ref_mem[int'(ad[7:2])] = e.wdata;
    last_rd[w] = e.rdata;
    gq.push_back(e);
    dq.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(a_gnt || b_gnt) && n < 40);
    chk("gnt_wait", n, next_wait);
    if (w) begin b_req = 1'b0; b_pend = 0; end
    else begin a_req = 1'b0; a_pend = 0; end
    next_wait = e.err ? 2 : MEM_LAT + 1;
  endtask

  initial begin
    int n;
    last_rd[0] = '0;
    last_rd[1] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_gnt", {30'b0, a_gnt, b_gnt}, 32'd0);
    chk("rst_done", {30'b0, a_done, b_done}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    rst_n = 1'b1;

    // Abandon an A read with a reset right after its grant
    set_req(0, 1'b0, 32'h10, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_gnt && n < 20);
    chk("pre_rst_gnt_wait", n, 1);
    a_req = 1'b0; a_pend = 0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("mid_rst_gnt", {30'b0, a_gnt, b_gnt}, 32'd0);
    chk("mid_rst_done", {30'b0, a_done, b_done}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", {30'b0, a_done, b_done}, 32'd0);
    end
    mon_en = 1;

    // Directed accesses
    next_wait = 1;
    set_req(0, 1'b0, 32'h10, 32'h0);
    issue();
    set_req(0, 1'b1, 32'h20, 32'h0102_0304);
    issue();
    set_req(0, 1'b0, 32'h20, 32'h0);
    issue();
    set_req(1, 1'b0, 32'h13, 32'h0);
    issue();
    set_req(1, 1'b1, 32'h40, 32'hCAFE_0001);
    issue();
    set_req(0, 1'b0, 32'h40, 32'h0);
    issue();

    // Both ports hammering: exercises the starvation limit
    for (int i = 0; i < 15; i++) begin
      spawn(1'b1);
      issue();
    end

    // Random mixed traffic
    for (int i = 0; i < 250; i++) begin
      spawn(1'b0);
      issue();
    end

    n = 0;
    while (dq.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (dq.size() > 0) fail("drain_timeout");
    repeat (3) @(negedge clk);

    for (int i = 0; i < 64; i++) begin
      chk("final_mem", wr_v[i] ? mem[i] : init_val(i), ref_rd(i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
